// File: rtl/dmem_access_unit.sv
// Load/store front end for a 2-cycle registered-output word RAM: sub-word extract/extend and read-modify-write.
// Optional misalignment trap enabled by defining DMEM_ALIGN_CHECK_EN; otherwise addresses are aligned down.
module dmem_access_unit #(
  parameter int RAM_DEPTH = 16,
  parameter int RAM_AW    = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [1:0]        req_size,
  input  logic              req_signed,
  input  logic [31:0]       req_addr,
  input  logic [31:0]       req_wdata,
  output logic              rsp_valid,
  output logic [31:0]       rsp_rdata,
  output logic              rsp_err,
  output logic [RAM_AW-1:0] ram_addr,
  output logic [31:0]       ram_din,
  output logic              ram_we,
  output logic              ram_en,
  output logic              ram_re,
  output logic              ram_rst,
  input  logic [31:0]       ram_dout
);

  typedef enum logic [1:0] {S_IDLE, S_READ, S_WAIT, S_FINISH} state_t;

  localparam logic [31:0] ADDR_MASK = 32'(4 * RAM_DEPTH - 1);

  state_t              r_state;
  state_t              w_next;
  logic                r_we;
  logic [1:0]          r_size;
  logic                r_signed;
  logic [1:0]          r_off;
  logic [RAM_AW-1:0]   r_widx;
  logic [31:0]         r_wdata;
  logic                r_mis;

  logic                w_accept;
  logic                w_req_mis;
  logic [1:0]          w_off;
  logic [31:0]         w_addr_m;
  logic                w_unused;
  logic [7:0]          w_lane_b;
  logic [15:0]         w_lane_h;
  logic [31:0]         w_merge;
  logic [31:0]         w_load;

  assign w_addr_m  = req_addr & ADDR_MASK;
  assign w_unused  = ^w_addr_m[31:RAM_AW+2];
  assign req_ready = (r_state == S_IDLE) && !reset;
  assign w_accept  = req_valid && req_ready;
  assign ram_rst   = reset;
  assign ram_addr  = r_widx;

`ifdef DMEM_ALIGN_CHECK_EN
  assign w_req_mis = ((req_size == 2'd1) && req_addr[0]) ||
                     (req_size[1] && (req_addr[1:0] != 2'b00));
`else
  assign w_req_mis = 1'b0;
`endif

  // Lane offset is aligned down to the access size; only bytes keep both bits.
  always_comb begin
    w_off = 2'b00;
    if (req_size == 2'd0)      w_off = req_addr[1:0];
    else if (req_size == 2'd1) w_off = {req_addr[1], 1'b0};
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state  <= S_IDLE;
      r_we     <= 1'b0;
      r_size   <= 2'd0;
      r_signed <= 1'b0;
      r_off    <= 2'd0;
      r_widx   <= '0;
      r_wdata  <= 32'd0;
      r_mis    <= 1'b0;
    end else begin
      r_state <= w_next;
      if (w_accept) begin
        r_we     <= req_we;
        r_size   <= req_size;
        r_signed <= req_signed;
        r_off    <= w_off;
        r_widx   <= w_addr_m[RAM_AW+1:2];
        r_wdata  <= req_wdata;
        r_mis    <= w_req_mis;
      end
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE: begin
        if (w_accept) begin
          if (w_req_mis || (req_we && req_size[1])) w_next = S_FINISH;
          else                                      w_next = S_READ;
        end
      end
      S_READ:   w_next = S_WAIT;
      S_WAIT:   w_next = S_FINISH;
      S_FINISH: w_next = S_IDLE;
      default:  w_next = S_IDLE;
    endcase
  end

  // Big-endian lanes: offset 0 is the most significant byte.
  always_comb begin
    w_lane_b = ram_dout[31:24];
    case (r_off)
      2'd1:    w_lane_b = ram_dout[23:16];
      2'd2:    w_lane_b = ram_dout[15:8];
      2'd3:    w_lane_b = ram_dout[7:0];
      default: w_lane_b = ram_dout[31:24];
    endcase
    w_lane_h = r_off[1] ? ram_dout[15:0] : ram_dout[31:16];
  end

  always_comb begin
    w_merge = ram_dout;
    if (r_size == 2'd0) begin
      case (r_off)
        2'd0:    w_merge[31:24] = r_wdata[7:0];
        2'd1:    w_merge[23:16] = r_wdata[7:0];
        2'd2:    w_merge[15:8]  = r_wdata[7:0];
        default: w_merge[7:0]   = r_wdata[7:0];
      endcase
    end else if (r_size == 2'd1) begin
      if (r_off[1]) w_merge[15:0]  = r_wdata[15:0];
      else          w_merge[31:16] = r_wdata[15:0];
    end else begin
      w_merge = r_wdata;
    end
  end

  always_comb begin
    w_load = ram_dout;
    if (r_size == 2'd0)
      w_load = r_signed ? {{24{w_lane_b[7]}}, w_lane_b} : {24'd0, w_lane_b};
    else if (r_size == 2'd1)
      w_load = r_signed ? {{16{w_lane_h[15]}}, w_lane_h} : {16'd0, w_lane_h};
  end

  always_comb begin
    ram_en    = 1'b0;
    ram_we    = 1'b0;
    ram_re    = 1'b0;
    ram_din   = 32'd0;
    rsp_valid = 1'b0;
    rsp_err   = 1'b0;
    rsp_rdata = 32'd0;
    case (r_state)
      S_READ: ram_en = 1'b1;
      S_WAIT: ram_re = 1'b1;
      S_FINISH: begin
        rsp_valid = 1'b1;
        if (r_mis) begin
          rsp_err = 1'b1;
        end else if (r_we) begin
          ram_en  = 1'b1;
          ram_we  = 1'b1;
          ram_din = w_merge;
        end else begin
          rsp_rdata = w_load;
        end
      end
      default: ;
    endcase
  end

endmodule
